// File: rtl/shift_pkg.sv
// Shared types and defaults for the iterative left shifter.
package shift_pkg;

  localparam int SHIFT_N_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/muxn.sv
// Generic one-bit N-input multiplexer.
module muxn #(
  parameter  int N  = 2,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  in_i,
  input  logic [SW-1:0] sel_i,
  output logic          out_o
);

  assign out_o = in_i[sel_i];

endmodule

// File: rtl/shl_pow2_stage.sv
// One barrel stage: shifts left by 2**k when enabled, else passes data through.
module shl_pow2_stage
  import shift_pkg::*;
#(
  parameter int N  = SHIFT_N_DEFAULT,
  parameter int KW = $clog2(N)
) (
  input  logic [N-1:0]  data_i,
  input  logic [KW-1:0] k_i,
  input  logic          en_i,
  output logic [N-1:0]  data_o
);

  logic [N-1:0] shifted;

  assign shifted = data_i << (32'd1 << k_i);

  for (genvar i = 0; i < N; i++) begin : g_bit
    muxn #(.N(2)) u_mux (
      .in_i  ({shifted[i], data_i[i]}),
      .sel_i (en_i),
      .out_o (data_o[i])
    );
  end

endmodule

// File: rtl/shift_left_iterative.sv
// Multi-cycle logical left shifter, one shamt bit resolved per clock.
// Optional SHIFT_LEFT_EARLY_DONE_EN: finish once no higher shamt bits remain.
//   state | meaning
//   IDLE  | ready for an operand
//   SHIFT | applying stage k_q
//   DONE  | result held until out_ready
module shift_left_iterative
  import shift_pkg::*;
#(
  parameter  int N     = SHIFT_N_DEFAULT,
  localparam int LOG2N = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic [LOG2N-1:0] in_shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [N-1:0]       data_q, data_d, stage_data;
  logic [LOG2N-1:0]   shamt_q, shamt_d;
  logic [LOG2N-1:0]   k_q, k_d;
  logic               accept;
  logic               last_stage;

  assign accept = in_valid && (state_q == IDLE);

  shl_pow2_stage #(.N(N), .KW(LOG2N)) u_stage (
    .data_i (data_q),
    .k_i    (k_q),
    .en_i   (shamt_q[k_q]),
    .data_o (stage_data)
  );

`ifdef SHIFT_LEFT_EARLY_DONE_EN
  logic [LOG2N-1:0] shamt_above;

  // Bits strictly above k_q; zero means the remaining stages are pass-through.
  assign shamt_above = (shamt_q >> k_q) >> 1;
  assign last_stage  = (k_q == LOG2N'(LOG2N - 1)) || (shamt_above == '0);
`else
  assign last_stage  = (k_q == LOG2N'(LOG2N - 1));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      shamt_q <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last_stage) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    shamt_d = shamt_q;
    k_d     = k_q;
    if (accept) begin
      data_d  = in_data;
      shamt_d = in_shamt;
      k_d     = '0;
    end else if (state_q == SHIFT) begin
      data_d  = stage_data;
      k_d     = k_q + LOG2N'(1);
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == SHIFT) || (state_q == DONE);
  end

  assign out_data = data_q;

endmodule
